// File: rtl/imem_loader_if.sv
// imem_loader_if
//   Bundles the loader byte stream, the CPU hold line and the instruction
//   fetch bus of imem_loader.
//   master : side that loads bytes and issues fetches (host / CPU / bench)
//   slave  : imem_loader itself
//   Signals:
//     ld_start      begin (re)load of program memory from address 0
//     ld_valid      loader byte valid
//     ld_data[7:0]  loader byte, opcode byte first, then immediate byte
//     ld_last       marks a low byte as the final word of the program
//     ld_ready      loader accepts a byte this cycle
//     ld_csum[7:0]  running checksum of accepted bytes
//     cpu_hold      CPU must be held in reset
//     im_abus_valid fetch request
//     im_abus_data  fetch word address
//     im_dbus       fetched instruction {opcode, immediate}
interface imem_loader_if;
  logic        ld_start;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic [7:0]  ld_csum;
  logic        cpu_hold;
  logic        im_abus_valid;
  logic [7:0]  im_abus_data;
  logic [15:0] im_dbus;

  modport master (
    output ld_start, ld_valid, ld_data, ld_last, im_abus_valid, im_abus_data,
    input  ld_ready, ld_csum, cpu_hold, im_dbus
  );

  modport slave (
    input  ld_start, ld_valid, ld_data, ld_last, im_abus_valid, im_abus_data,
    output ld_ready, ld_csum, cpu_hold, im_dbus
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader
//   256 x 16-bit instruction memory that is filled from a byte-wide loader
//   stream and then serves registered (latency 1) instruction fetches.
//   The CPU is held in reset while the memory is idle or being loaded.
//
//   Parameters:
//     NOP_WORD  word driven on im_dbus whenever the block is not in RUN
//     AUTO_RUN  1: leave IDLE for RUN right after reset without a load
//   Ports:
//     clk    single clock, rising edge
//     reset  asynchronous, active-low
//     bus    imem_loader_if.slave (loader stream, cpu_hold, fetch bus)
//   Build option:
//     IMEM_CHECKSUM_EN  when defined, ld_csum accumulates every accepted
//                       byte mod 256; otherwise ld_csum is tied to 0.
module imem_loader #(
  parameter logic [15:0] NOP_WORD = 16'h0000,
  parameter bit          AUTO_RUN = 1'b0
) (
  input logic          clk,
  input logic          reset,
  imem_loader_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD_HI = 2'd1,
    LOAD_LO = 2'd2,
    RUN     = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic        ld_ready_q, ld_ready_d;
  logic        cpu_hold_q, cpu_hold_d;
  logic [15:0] im_dbus_q, im_dbus_d;

  // Storage and the latched opcode byte are plain data: never reset.
  logic [15:0] mem_q [256];
  logic [7:0]  hi_q;

  logic xfer;
  logic hi_en;
  logic wr_en;
  logic restart;

  // ld_ready_q is only high in LOAD_HI/LOAD_LO, so a reset that forces IDLE
  // also kills any pending write of a half-loaded word.
  assign xfer    = bus.ld_valid & ld_ready_q;
  assign hi_en   = xfer & (state_q == LOAD_HI);
  assign wr_en   = xfer & (state_q == LOAD_LO);
  // ld_start is honoured only outside a load.
  assign restart = bus.ld_start & ((state_q == IDLE) | (state_q == RUN));

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    im_dbus_d = NOP_WORD;
    case (state_q)
      IDLE: begin
        if (bus.ld_start) begin
          state_d = LOAD_HI;
          addr_d  = 8'h00;
        end else if (AUTO_RUN) begin
          state_d = RUN;
        end
      end
      LOAD_HI: begin
        if (hi_en) state_d = LOAD_LO;
      end
      LOAD_LO: begin
        if (wr_en) begin
          addr_d = addr_q + 8'd1;
          // Writing address 255 fills the memory and ends the load even
          // without ld_last.
          if (bus.ld_last || (addr_q == 8'hFF)) state_d = RUN;
          else                                  state_d = LOAD_HI;
        end
      end
      RUN: begin
        if (bus.ld_start) begin
          // A fetch in the same cycle is dropped; NOP goes out next cycle.
          state_d = LOAD_HI;
          addr_d  = 8'h00;
        end else if (bus.im_abus_valid) begin
          im_dbus_d = mem_q[bus.im_abus_data];
        end else begin
          im_dbus_d = im_dbus_q;
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered from the next state so they line up with it.
    ld_ready_d = (state_d == LOAD_HI) || (state_d == LOAD_LO);
    cpu_hold_d = (state_d != RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= 8'h00;
      ld_ready_q <= 1'b0;
      cpu_hold_q <= 1'b1;
      im_dbus_q  <= NOP_WORD;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      ld_ready_q <= ld_ready_d;
      cpu_hold_q <= cpu_hold_d;
      im_dbus_q  <= im_dbus_d;
    end
  end

  always_ff @(posedge clk) begin
    if (hi_en) hi_q <= bus.ld_data;
    if (wr_en) mem_q[addr_q] <= {hi_q, bus.ld_data};
  end

`ifdef IMEM_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (restart)   csum_d = 8'h00;
    else if (xfer) csum_d = csum_q + bus.ld_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) csum_q <= 8'h00;
    else        csum_q <= csum_d;
  end

  assign bus.ld_csum = csum_q;
`else
  logic unused_restart;
  assign unused_restart = restart;
  assign bus.ld_csum    = 8'h00;
`endif

  assign bus.ld_ready = ld_ready_q;
  assign bus.cpu_hold = cpu_hold_q;
  assign bus.im_dbus  = im_dbus_q;

endmodule
